// File: rtl/ds_dac_pkg.sv
// rtl/ds_dac_pkg.sv - shared types and arithmetic helpers for the delta-sigma DAC
//   ds_order_t : modulator order selector (ORD1, ORD2)
//   fb_mag     : feedback magnitude 2^(width-1) for a given sample width
//   sat_add    : signed add clamped to the range of a dst_w-bit destination
package ds_dac_pkg;

  typedef enum logic {
    ORD1 = 1'b0,
    ORD2 = 1'b1
  } ds_order_t;

  function automatic int fb_mag(input int width);
    return 1 << (width - 1);
  endfunction

  // Operands are carried at 64 bits so callers of any width up to 63 can
  // share one helper; the result always fits in dst_w signed bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 dst_w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (dst_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dst_w - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/ds_dac_mc_ch.sv
// rtl/ds_dac_mc_ch.sv - single-channel first/second-order delta-sigma modulator
//   clk, rst : clock, asynchronous active-high reset
//   tick     : modulator update strobe (already qualified by clk_en)
//   x        : unsigned WIDTH-bit sample used on this tick
//   dout     : 1-bit pulse-density output
//   ovf      : sticky integrator saturation flag (always 0 for ORDER=1)
module ds_mod_ch
  import ds_dac_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ORDER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] x,
  output logic             dout,
  output logic             ovf
);

  localparam ds_order_t ORD = (ORDER == 2) ? ORD2 : ORD1;

  generate
    if (ORD == ORD1) begin : g_ord1
      // Only the low WIDTH bits of the accumulator carry over; the carry
      // bit of each sum becomes the output bit directly.
      logic [WIDTH-1:0] r_acc;
      logic             r_dout;
      logic [WIDTH:0]   w_acc_next;

      assign w_acc_next = {1'b0, r_acc} + {1'b0, x};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc  <= '0;
          r_dout <= 1'b0;
        end else if (tick) begin
          r_acc  <= w_acc_next[WIDTH-1:0];
          r_dout <= w_acc_next[WIDTH];
        end
      end

      assign dout = r_dout;
      assign ovf  = 1'b0;
    end else begin : g_ord2
      localparam logic signed [63:0] FB = 64'(fb_mag(WIDTH));

      logic signed [WIDTH+1:0] r_i1;
      logic signed [WIDTH+3:0] r_i2;
      logic                    r_dout;
      logic                    r_ovf;
      logic signed [63:0]      w_xs;
      logic signed [63:0]      w_fb;
      logic signed [63:0]      w_sum1;
      logic signed [63:0]      w_sat1;
      logic signed [63:0]      w_sum2;
      logic signed [63:0]      w_sat2;
      logic signed [WIDTH+1:0] w_i1_next;
      logic signed [WIDTH+3:0] w_i2_next;

      // Re-centre the unsigned sample around zero.
      assign w_xs = $signed(64'(x)) - FB;
      assign w_fb = r_dout ? FB : -FB;

      assign w_sum1    = 64'(r_i1) + (w_xs - w_fb);
      assign w_sat1    = sat_add(64'(r_i1), w_xs - w_fb, WIDTH + 2);
      assign w_i1_next = w_sat1[WIDTH+1:0];

      assign w_sum2    = 64'(r_i2) + (64'(w_i1_next) - w_fb);
      assign w_sat2    = sat_add(64'(r_i2), 64'(w_i1_next) - w_fb, WIDTH + 4);
      assign w_i2_next = w_sat2[WIDTH+3:0];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_i1   <= '0;
          r_i2   <= '0;
          r_dout <= 1'b0;
          r_ovf  <= 1'b0;
        end else if (tick) begin
          r_i1   <= w_i1_next;
          r_i2   <= w_i2_next;
          r_dout <= ~w_i2_next[WIDTH+3];
          // A clamp shows up as the saturated sum differing from the true sum.
          r_ovf  <= r_ovf | (w_sat1 != w_sum1) | (w_sat2 != w_sum2);
        end
      end

      assign dout = r_dout;
      assign ovf  = r_ovf;
    end
  endgenerate

endmodule

// File: rtl/ds_dac_mc.sv
// rtl/ds_dac_mc.sv - multi-channel delta-sigma DAC: tick divider, double buffer, channels
//   clk, rst  : 50 MHz clock, asynchronous active-high reset
//   clk_en    : global enable, freezes divider and modulators when low
//   din       : CHANNELS packed unsigned samples, channel c at [c*WIDTH +: WIDTH]
//   din_valid : din holds a valid sample set
//   din_ready : holding buffer free
//   ce_out    : one-cycle pulse when dout presents a new value
//   dout      : per-channel 1-bit modulator output
//   ovf       : per-channel sticky saturation flag
module ds_dac_mc
  import ds_dac_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int ORDER    = 1,
  parameter int OSR_DIV  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic                      ce_out,
  output logic [CHANNELS-1:0]       dout,
  output logic [CHANNELS-1:0]       ovf
);

  localparam int              CNT_W    = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR_DIV - 1);

  logic [CNT_W-1:0]          r_cnt;
  logic                      r_pending;
  logic                      r_ce;
  logic [CHANNELS*WIDTH-1:0] r_hold;
  logic [CHANNELS*WIDTH-1:0] r_active;

  logic                      w_tick;
  logic                      w_accept;
  logic [CHANNELS*WIDTH-1:0] w_x;

  assign w_tick   = clk_en & (r_cnt == CNT_LAST);
  assign w_accept = din_valid & ~r_pending;

  // A sample accepted on the tick edge itself bypasses the holding buffer.
  assign w_x = w_accept ? din : (r_pending ? r_hold : r_active);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_ce      <= 1'b0;
      r_hold    <= '0;
      r_active  <= '0;
    end else begin
      r_ce <= w_tick;
      if (clk_en) begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      end
      if (w_tick) begin
        r_active  <= w_x;
        r_pending <= 1'b0;
      end else if (w_accept) begin
        r_hold    <= din;
        r_pending <= 1'b1;
      end
    end
  end

  assign din_ready = ~r_pending;
  assign ce_out    = r_ce;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      ds_mod_ch #(
        .WIDTH (WIDTH),
        .ORDER (ORDER)
      ) u_ch (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick),
        .x    (w_x[c*WIDTH +: WIDTH]),
        .dout (dout[c]),
        .ovf  (ovf[c])
      );
    end
  endgenerate

endmodule

// File: doc/ds_dac_mc.md
# ds_dac_mc

Parametrised, multi-channel delta-sigma DAC modulator that replaces the single-channel 16-bit first-order `ds_dac`. It converts CHANNELS unsigned WIDTH-bit samples into 1-bit pulse-density streams, one stream per channel. The modulator order (1 or 2) and the modulator update rate are selectable. Samples arrive on a valid/ready handshake into a double buffer. Each `dout` bit feeds an external RC filter.

## Interface
- WIDTH, 16: sample width per channel (unsigned); must be ≥ 4.
- CHANNELS, 2: number of independent channels; must be ≥ 1.
- ORDER, 1: modulator order; legal values are 1 and 2.
- OSR_DIV, 1: modulator ticks once every OSR_DIV enabled clocks; must be ≥ 1.

- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  global enable; while low, all state is frozen.
- din  in  CHANNELS*WIDTH  packed samples; channel c occupies bits [c*WIDTH +: WIDTH].
- din_valid  in  1  all channels of `din` are valid.
- din_ready  out  1  holding buffer is free.
- ce_out  out  1  one-cycle pulse, high in the cycle in which `dout` presents a new value.
- dout  out  CHANNELS  1-bit modulator outputs.
- ovf  out  CHANNELS  sticky per-channel integrator saturation flag (ORDER=2 only; tied 0 when ORDER=1).

## Operation
- **Tick divider:**
  - Counter `cnt` runs 0..OSR_DIV-1 and advances only when clk_en=1.
  - A tick occurs on an edge where clk_en=1 and cnt=OSR_DIV-1.
  - `ce_out` is a register that is set to 1 on a tick edge and to 0 on every other edge.
- **Input double buffer:**
  - An accept is an edge where din_valid=1 and din_ready=1.
  - din_ready = ~pending.
  - Accept on a non-tick edge: hold <= din and pending <= 1.
  - On a tick edge, the modulator input is x = din if an accept occurs on that same edge, else hold if pending=1, else active. At that edge active <= x and pending <= 0.
  - With no new sample, the modulator keeps reusing `active`.
  - Accepts are not gated by clk_en.
- **ORDER=1, per channel:**
  - acc is WIDTH+1 bits; acc <= acc[WIDTH-1:0] + x; dout <= carry (acc_next[WIDTH]).
- **ORDER=2, per channel, error feedback, two's complement:**
  - xs = x − 2^(WIDTH-1), sign-extended to WIDTH+1 bits.
  - fb = +2^(WIDTH-1) if the current dout is 1, else −2^(WIDTH-1).
  - i1 (WIDTH+2 bits) <= sat(i1 + xs − fb).
  - i2 (WIDTH+4 bits) <= sat(i2 + i1_next − fb).
  - dout <= (i2_next ≥ 0).
  - sat() clamps to the signed range of the destination; any clamp sets ovf[c], which is cleared only by rst.
- Mean output density is x/2^WIDTH for both orders.
- Channels are fully independent and share only the tick and the handshake.

## Timing
- Reset values (asynchronous): cnt=0, pending=0, din_ready=1, hold=0, active=0, all accumulators/integrators=0, dout=0, ce_out=0, ovf=0.
- With OSR_DIV=1 and clk_en=1, every edge is a tick.
- Latency: a sample accepted at edge k affects `dout` at the first tick edge ≥ k.
- A second sample offered while pending=1 stalls (din_ready=0) until the next tick edge. din_ready returns to 1 in the cycle after that edge.
- clk_en=0: cnt, the modulator state and dout hold their values. ce_out goes to 0 on the next edge.
- rst asserted mid-operation: outputs take their reset values immediately, without waiting for clk. A pending sample is discarded.
- ORDER=1 boundaries:
  - x=0 gives dout constantly 0.
  - x=2^WIDTH−1 gives dout=1 on all but one tick in every 2^WIDTH ticks.
  - acc wraps modulo 2^WIDTH.

## Structure
- Package `ds_dac_pkg` contains:
  - `ds_order_t` enum (ORD1, ORD2);
  - a function `sat_add` parameterised by destination width;
  - a localparam function giving fb magnitude for a given WIDTH.
- Sub-module `ds_mod_ch`:
  - a single-channel modulator with inputs clk, rst, tick and x, and outputs dout and ovf;
  - instantiated CHANNELS times in a generate loop.
- The top level holds the divider, the handshake and the buffers.

## Test plan
- **Mid-scale, ORDER=1:** WIDTH=16, ORDER=1, OSR_DIV=1, x=0x8000 on channel 0 → dout[0] alternates 0,1 from the first tick; exactly 32 ones in 64 ticks.
- **Quarter-scale and channel independence:** x=0x4000 on ch0 and x=0x0000 on ch1 → ch0 repeats the pattern 0,0,0,1 (256 ones in 1024 ticks); ch1 stays at 0.
- **ORDER=2 density and saturation:** x=0xC000 → 3072±2 ones in 4096 ticks, ovf=0. Then x=0xFFFF for 10^5 ticks → ovf remains 0 or sets, and once set stays set until rst.
- **Handshake stall:** OSR_DIV=4; din_valid held high with new data on 2 consecutive edges after a tick → the first is accepted; din_ready is low until the next tick; the second is accepted in the cycle after that tick. ce_out pulses every 4 clocks.
- **clk_en gating:** drop clk_en for 7 cycles mid-stream → no ce_out pulses; dout and cnt are frozen; the ones count resumes with no lost or extra tick.
- **Asynchronous reset:** assert rst at a time not aligned to clk, with pending=1 → dout=0, ce_out=0, din_ready=1 before the next edge. After release, the first tick uses active=0.
